// File: rtl/tilemap_read_arbiter.sv
// Round-robin arbiter that shares the tilemap read port between NUM_REQ clients, optionally
// giving requester 0 absolute priority. Only one read is in flight at a time.
module tilemap_read_arbiter #(
  parameter int unsigned NUM_REQ     = 3,
  parameter int unsigned ADDR_WIDTH  = 15,
  parameter int unsigned DATA_WIDTH  = 3,
  parameter int unsigned MEM_LATENCY = 1,
  parameter bit          PRIORITY0   = 1'b0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]         mem_data,
  output logic [ADDR_WIDTH-1:0]         mem_address,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          busy
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned CntW = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StReturn} state_e;

  state_e                  state_q, state_d;
  logic [IdxW-1:0]         ptr_q, ptr_d;
  logic [IdxW-1:0]         owner_q, owner_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [NUM_REQ-1:0]      gnt_q, gnt_d;
  logic [NUM_REQ-1:0]      rvalid_q, rvalid_d;

  logic                    win_valid;
  logic [IdxW-1:0]         win_idx;
  logic [IdxW-1:0]         cand;

  // Scan from the farthest candidate back to ptr+1 so the nearest requester wins.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IdxW'((int'(ptr_q) + k) % int'(NUM_REQ));
      if (req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
    if (PRIORITY0 && req[0]) begin
      win_valid = 1'b1;
      win_idx   = '0;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    rdata_d  = rdata_q;
    gnt_d    = '0;
    rvalid_d = '0;
    unique case (state_q)
      StIdle: begin
        if (win_valid) begin
          state_d        = StIssue;
          ptr_d          = win_idx;
          owner_d        = win_idx;
          addr_d         = addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
          gnt_d[win_idx] = 1'b1;
        end
      end
      StIssue: begin
        cnt_d   = CntW'(MEM_LATENCY - 1);
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q == '0) begin
          rdata_d           = mem_data;
          rvalid_d[owner_q] = 1'b1;
          state_d           = StReturn;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StReturn: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      ptr_q    <= IdxW'(NUM_REQ - 1);
      owner_q  <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      rdata_q  <= '0;
      gnt_q    <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      rdata_q  <= rdata_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign mem_address = addr_q;
  assign gnt         = gnt_q;
  assign rvalid      = rvalid_q;
  assign rdata       = rdata_q;
  assign busy        = (state_q != StIdle);

endmodule
